// File: rtl/alu_muldiv.sv
// EX-stage ALU with registered result plus iterative mult/div and HI/LO.
// Optional: define ALU_OVERFLOW_EN to add the signed-overflow output.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       Alu_op,
    input  logic [5:0]       funct,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] rem, quo, mcand, a_q;
    logic             neg_q, neg_r, dz;

    logic             is_mul, is_div, sgn, last;
    logic [WIDTH-1:0] a_mag, b_mag, alu_res;
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf, alu_ovf;
    logic [WIDTH:0]   msum, shifted;
    logic [2*WIDTH-1:0] prod_step, mul_fin;
    logic [WIDTH-1:0] rdiff, rem_step, quo_step;
    logic [WIDTH-1:0] lo_fin, hi_fin;
    logic             ge;

    // Operand decode: mult/div class and magnitudes for the iterative unit
    always_comb begin
        is_mul = Alu_op[1] && (funct[5:1] == 5'b01100);
        is_div = Alu_op[1] && (funct[5:1] == 5'b01101);
        sgn    = ~funct[0];
        a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
        last   = (cnt == CW'(WIDTH - 1));
    end

    // Single-cycle ALU result and signed-overflow detection
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (Alu_op)
            2'b00: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            2'b01: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            default: begin
                unique case (funct)
                    6'b100000: begin
                        alu_res = sum;
                        alu_ovf = add_ovf;
                    end
                    6'b100001: alu_res = sum;
                    6'b100010: begin
                        alu_res = diff;
                        alu_ovf = sub_ovf;
                    end
                    6'b100011: alu_res = diff;
                    6'b100100: alu_res = a & b;
                    6'b100101: alu_res = a | b;
                    6'b100110: alu_res = a ^ b;
                    6'b100111: alu_res = ~(a | b);
                    6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                    6'b101011: alu_res = {{(WIDTH-1){1'b0}}, a < b};
                    6'b010000: alu_res = hi;
                    6'b010010: alu_res = lo;
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

    // One shift-add and one restoring-divide step, plus sign fix-up
    always_comb begin
        msum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        prod_step = prod[0] ? {msum, prod[WIDTH-1:1]}
                            : {1'b0, prod[2*WIDTH-1:1]};
        mul_fin   = neg_q ? -prod_step : prod_step;
        shifted   = {rem, quo[WIDTH-1]};
        ge        = (shifted >= {1'b0, mcand});
        rdiff     = shifted[WIDTH-1:0] - mcand;
        rem_step  = ge ? rdiff : shifted[WIDTH-1:0];
        quo_step  = {quo[WIDTH-2:0], ge};
        lo_fin    = dz ? '1 : (neg_q ? -quo_step : quo_step);
        hi_fin    = dz ? a_q : (neg_r ? -rem_step : rem_step);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && is_mul)      state_nxt = MUL;
                else if (start && is_div) state_nxt = DIV;
            end
            MUL, DIV: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status output
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: operand capture, iteration, result and HI/LO write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            mcand  <= '0;
            a_q    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        mcand <= b_mag;
                        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= sgn && a[WIDTH-1];
                        dz    <= (b == '0);
                        a_q   <= a;
                        if (is_mul) begin
                            prod <= {{WIDTH{1'b0}}, a_mag};
                        end else if (is_div) begin
                            quo <= a_mag;
                            rem <= '0;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
`ifdef ALU_OVERFLOW_EN
                            overflow <= alu_ovf;
`endif
                        end
                    end
                end
                MUL: begin
                    prod <= prod_step;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        hi     <= mul_fin[2*WIDTH-1:WIDTH];
                        lo     <= mul_fin[WIDTH-1:0];
                        result <= mul_fin[WIDTH-1:0];
                        zero   <= (mul_fin[WIDTH-1:0] == '0);
                        done   <= 1'b1;
                        cnt    <= '0;
`ifdef ALU_OVERFLOW_EN
                        overflow <= 1'b0;
`endif
                    end
                end
                DIV: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi     <= hi_fin;
                        lo     <= lo_fin;
                        result <= lo_fin;
                        zero   <= (lo_fin == '0);
                        done   <= 1'b1;
                        cnt    <= '0;
`ifdef ALU_OVERFLOW_EN
                        overflow <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef ALU_OVERFLOW_EN
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
`endif

endmodule
